// File: rtl/tt_um_first_asic_if.sv
// Pin bundle for the blink counter: enable, dedicated and bidirectional pins.
// master drives ena/ui_in/uio_in; slave (the design) drives uo_out/uio_*.
interface tt_um_first_asic_if;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (
      output ena, ui_in, uio_in,
      input  uo_out, uio_out, uio_oe
   );

   modport slave (
      input  ena, ui_in, uio_in,
      output uo_out, uio_out, uio_oe
   );
endinterface

// File: rtl/tt_um_first_asic.sv
// Free-running blink counter with selectable LED tap, invert, clear, pause.
// Ports: clk, rst_n (async low), bus.slave (ena, ui_in, uo_out, uio_*).
module tt_um_first_asic #(
   parameter int CNT_WIDTH = 24
) (
   input  logic                clk,
   input  logic                rst_n,
   tt_um_first_asic_if.slave   bus
);

   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] tapped;
   logic                 clr;
   logic                 pause;
   logic                 led_raw;
   logic                 unused_pins;

   assign clr   = bus.ui_in[4];
   assign pause = bus.ui_in[7];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (bus.ena && !pause) begin
         cnt <= cnt + CNT_WIDTH'(1);
      end
   end

   // Shifting left by the tap select moves bit (MSB - sel) into the MSB,
   // which avoids a variable bit index.
   assign tapped  = cnt << bus.ui_in[2:0];
   assign led_raw = tapped[CNT_WIDTH-1];

   assign bus.uo_out  = {cnt[CNT_WIDTH-1 -: 7], led_raw ^ bus.ui_in[3]};
   assign bus.uio_out = cnt[7:0];
   assign bus.uio_oe  = 8'hFF;

   assign unused_pins = ^{bus.uio_in, bus.ui_in[6:5]};

endmodule

// File: tb/tb_tt_um_first_asic.sv
// Directed bench for tt_um_first_asic at CNT_WIDTH 24 and 16.
// Two instances share clk/rst_n; each has its own pin bundle.
module tb_tt_um_first_asic;

   logic clk;
   logic rst_n;
   int   nvec;
   int   nfail;

   tt_um_first_asic_if bus ();
   tt_um_first_asic_if bus16 ();

   tt_um_first_asic #(.CNT_WIDTH(24)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   tt_um_first_asic #(.CNT_WIDTH(16)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus16)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [23:0] exp_cnt;
      nvec  = 0;
      nfail = 0;
      rst_n = 1'b0;
      bus.ena = 1'b1;
      bus.ui_in = 8'h00;
      bus.uio_in = 8'h00;
      bus16.ena = 1'b0;
      bus16.ui_in = 8'h00;
      bus16.uio_in = 8'h00;

      // reset state
      #50;
      check("rst_uio_out", 32'(bus.uio_out), 32'h00);
      check("rst_uo_out", 32'(bus.uo_out), 32'h00);
      check("rst_uio_oe", 32'(bus.uio_oe), 32'hFF);
      bus.ui_in = 8'h08;
      #1;
      check("rst_led_inv", 32'(bus.uo_out), 32'h01);
      bus.ui_in = 8'h00;
      #49;
      rst_n = 1'b1;

      // 100 edges after release
      step(100);
      check("cnt100_uio", 32'(bus.uio_out), 32'h64);
      check("cnt100_uo", 32'(bus.uo_out), 32'h00);

      // pause and enable hold
      bus.ui_in = 8'h10;
      step(1);
      check("clr", 32'(bus.uio_out), 32'h00);
      bus.ui_in = 8'h00;
      step(50);
      check("cnt50", 32'(bus.uio_out), 32'h32);
      bus.ui_in = 8'h80;
      step(20);
      check("pause_hold", 32'(bus.uio_out), 32'h32);
      bus.ui_in = 8'h00;
      step(10);
      check("resume", 32'(bus.uio_out), 32'h3C);
      bus.ena = 1'b0;
      step(20);
      check("ena_hold", 32'(bus.uio_out), 32'h3C);
      bus.ena = 1'b1;
      step(1);
      check("ena_resume", 32'(bus.uio_out), 32'h3D);

      // clear pulse, then resume 1,2,3
      bus.ui_in = 8'h10;
      step(1);
      bus.ui_in = 8'h00;
      step(40);
      check("cnt40", 32'(bus.uio_out), 32'h28);
      bus.ui_in = 8'h10;
      step(1);
      check("clr40", 32'(bus.uio_out), 32'h00);
      bus.ui_in = 8'h00;
      for (int i = 1; i <= 3; i++) begin
         step(1);
         check("after_clr", 32'(bus.uio_out), 32'(i));
      end
      bus.ui_in = 8'h90;
      step(1);
      check("clr_paused", 32'(bus.uio_out), 32'h00);
      bus.ui_in = 8'h10;
      bus.ena = 1'b0;
      step(2);
      bus.ui_in = 8'h00;
      bus.ena = 1'b1;
      step(1);
      check("clr_no_ena", 32'(bus.uio_out), 32'h01);

      // LED invert is combinational
      bus.ui_in = 8'h0F;
      #1;
      check("inv_same_cycle", 32'(bus.uo_out), 32'h01);
      bus.ui_in = 8'h00;
      #1;
      check("inv_off", 32'(bus.uo_out), 32'h00);

      // async reset mid-count
      bus.ui_in = 8'h10;
      step(1);
      bus.ui_in = 8'h00;
      step(119);
      check("cnt77", 32'(bus.uio_out), 32'h77);
      #5;
      rst_n = 1'b0;
      #1;
      check("async_rst_uio", 32'(bus.uio_out), 32'h00);
      check("async_rst_oe", 32'(bus.uio_oe), 32'hFF);
      check("async_rst_uo", 32'(bus.uo_out), 32'h00);
      #3;
      rst_n = 1'b1;
      step(1);
      check("post_rst", 32'(bus.uio_out), 32'h01);

      // unused pins have no effect
      exp_cnt = 24'd1;
      for (int i = 0; i < 30; i++) begin
         bus.uio_in = 8'($urandom);
         bus.ui_in = {1'b0, 2'($urandom), 5'b0};
         step(1);
         exp_cnt = exp_cnt + 24'd1;
         check("unused_uio", 32'(bus.uio_out), 32'(exp_cnt[7:0]));
         check("unused_uo", 32'(bus.uo_out), 32'h00);
      end
      bus.uio_in = 8'h00;
      bus.ui_in = 8'h00;

      // 16-bit instance, tap 7 selects bit 8
      bus16.ena = 1'b1;
      bus16.ui_in = 8'h17;
      step(1);
      check("w16_clr", 32'({bus16.uo_out, bus16.uio_out}), 32'h0000);
      bus16.ui_in = 8'h07;
      step(255);
      check("w16_255", 32'({bus16.uo_out, bus16.uio_out}), 32'h00FF);
      step(1);
      check("w16_256", 32'({bus16.uo_out, bus16.uio_out}), 32'h0100);
      bus16.ui_in = 8'h0F;
      #1;
      check("w16_inv", 32'(bus16.uo_out), 32'h00);
      bus16.ui_in = 8'h07;
      #1;
      check("w16_inv_off", 32'(bus16.uo_out), 32'h01);
      step(65279);
      check("w16_ffff", 32'({bus16.uo_out, bus16.uio_out}), 32'hFFFF);
      step(1);
      check("w16_wrap", 32'({bus16.uo_out, bus16.uio_out}), 32'h0000);
      bus16.ui_in = 8'h00;
      #1;
      check("w16_tap0", 32'(bus16.uo_out), 32'h00);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/tt_um_first_asic.md
TT_UM_FIRST_ASIC -- requirements
Module: tt_um_first_asic

Interface
REQ-001 Parameter: CNT_WIDTH, default 24, width of the free-running blink counter; legal range 16..32.
REQ-002 Port: clk  input  1  system clock, rising-edge active, nominal 50 MHz.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: ena  input  1  design enable; high = counter may advance.
REQ-005 Port: ui_in  input  8  controls: [2:0] tap select, [3] LED invert, [4] synchronous clear, [7] pause, [6:5] unused.
REQ-006 Port: uo_out  output  8  [0] LED, [7:1] counter[CNT_WIDTH-1 -: 7].
REQ-007 Port: uio_in  input  8  unused, ignored.
REQ-008 Port: uio_out  output  8  counter[7:0].
REQ-009 Port: uio_oe  output  8  constant 8'hFF, all bidirectional pins driven as outputs.
REQ-010 Single clock domain (clk); reset is asynchronous assert, active-low (rst_n); no other clocks or resets.

Function
REQ-011 Internal register cnt, CNT_WIDTH bits, unsigned; the only state element.
REQ-012 Per rising clk edge, priority order: ui_in[4]=1 -> cnt <= 0; else ena=1 and ui_in[7]=0 -> cnt <= cnt+1; else cnt holds.
REQ-013 Clear (ui_in[4]) is honoured regardless of ena and pause.
REQ-014 Increment is modulo 2^CNT_WIDTH: all-ones wraps to 0 with no flag, no stall.
REQ-015 Tap index t = CNT_WIDTH-1-ui_in[2:0]; raw LED = cnt[t].
REQ-016 uo_out[0] = raw LED XOR ui_in[3].
REQ-017 uo_out[7:1] = cnt[CNT_WIDTH-1:CNT_WIDTH-7]; uio_out = cnt[7:0].
REQ-018 All outputs combinational from cnt and ui_in only; changes to ui_in[3:0] reflect on uo_out[0] in the same cycle, no register latency.
REQ-019 A counter update becomes visible on uo_out/uio_out immediately after the clk edge that performs it (zero added latency).
REQ-020 LED period with tap 0 = 2^CNT_WIDTH cycles (default ~0.335 s at 50 MHz, 50% duty); each tap step halves the period.
REQ-021 uio_in and ui_in[6:5] have no effect on any output or state.
REQ-022 No X propagation: every output defined for all input values once reset has been applied.

Reset
REQ-023 rst_n=0 forces cnt to 0 immediately, independent of clk.
REQ-024 During reset: uio_out=8'h00, uo_out[7:1]=0, uo_out[0]=ui_in[3], uio_oe=8'hFF.
REQ-025 After rst_n rises, first increment occurs on the first rising clk edge with ena=1, ui_in[7]=0, ui_in[4]=0.
REQ-026 Reset asserted mid-count discards count; no state survives reset.

Verification
REQ-027 Reset held 100 ns, ui_in=0, ena=1, release, 100 clk edges -> uio_out=8'h64, uo_out=8'h00.
REQ-028 Count to 50, set ui_in[7]=1 for 20 cycles -> uio_out stays 8'h32; clear ui_in[7], 10 cycles -> 8'h3C; same hold with ena=0.
REQ-029 Count to 40, pulse ui_in[4] one cycle (also with ui_in[7]=1) -> uio_out=8'h00 after that edge, then counting resumes 1,2,3.
REQ-030 CNT_WIDTH=16, ui_in[2:0]=3'd7 (tap bit 8): LED low for cycles 0..255, high at cnt=256, wraps 0xFFFF->0x0000 with LED low; ui_in[3]=1 inverts LED same cycle.
REQ-031 Assert rst_n=0 asynchronously between clk edges at cnt=0x77 -> uio_out=8'h00 before next clk edge; uio_oe=8'hFF throughout.
REQ-032 Toggle uio_in and ui_in[6:5] randomly during counting -> outputs identical to run with them held at 0.
